// File: rtl/alu_execute_unit.sv
// alu_execute_unit: execute stage behind the 16x16 register file.
// Runs seven single-cycle ops and a 16-step shift-add MUL that stalls issue.
// Ports:
//   clk, rst (sync, active-high)
//   start, op[2:0], dr_in[3:0], A, B : issue side
//   busy : MUL in flight, start ignored
//   done, RegW[1:0], DR[3:0], Write_data, Z, C : register-file write side
module alu_execute_unit #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [3:0]       dr_in,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [1:0]       RegW,
    output logic [3:0]       DR,
    output logic [WIDTH-1:0] Write_data,
    output logic             Z,
    output logic             C
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [1:0] REGW_SINGLE = 2'b01;
    localparam logic [1:0] REGW_MULTI  = 2'b11;
    localparam logic [1:0] REGW_OFF    = 2'b10;

    localparam logic [4:0] LAST_CNT = 5'(MUL_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t r_state;
    state_t w_next;

    logic             r_done;
    logic [1:0]       r_regw;
    logic [3:0]       r_dr;
    logic [WIDTH-1:0] r_wdata;
    logic             r_z;
    logic             r_c;

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mpy;
    logic [4:0]         r_cnt;
    logic [3:0]         r_mdr;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic [3:0]         w_shamt;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_mul_last;

    assign w_sum   = {1'b0, A} + {1'b0, B};
    // Bit WIDTH of the widened difference is the unsigned borrow.
    assign w_diff  = {1'b0, A} - {1'b0, B};
    assign w_shamt = B[3:0];
    // One guard bit on each shift catches the last bit shifted out;
    // a zero shift leaves the guard bit clear.
    assign w_shl   = {1'b0, A} << w_shamt;
    assign w_shr   = {A, 1'b0} >> w_shamt;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        unique case (op)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
            end
            OP_AND: w_res = A & B;
            OP_OR:  w_res = A | B;
            OP_XOR: w_res = A ^ B;
            OP_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            OP_MUL: begin
                w_res = '0;
                w_c   = 1'b0;
            end
        endcase
    end

    assign w_acc_next = r_mpy[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mul_last = (r_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start && op == OP_MUL) begin
                    w_next = S_MUL;
                end
            end
            S_MUL: begin
                if (w_mul_last) begin
                    w_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done  <= 1'b0;
            r_regw  <= REGW_OFF;
            r_dr    <= '0;
            r_wdata <= '0;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_mpy   <= '0;
            r_cnt   <= '0;
            r_mdr   <= '0;
        end else begin
            r_done <= 1'b0;
            r_regw <= REGW_OFF;
            unique case (r_state)
                S_IDLE: begin
                    if (start && op != OP_MUL) begin
                        r_done  <= 1'b1;
                        r_regw  <= REGW_SINGLE;
                        r_dr    <= dr_in;
                        r_wdata <= w_res;
                        r_z     <= (w_res == '0);
                        r_c     <= w_c;
                    end else if (start) begin
                        r_acc   <= '0;
                        r_mcand <= {{WIDTH{1'b0}}, A};
                        r_mpy   <= B;
                        r_cnt   <= '0;
                        r_mdr   <= dr_in;
                    end
                end
                S_MUL: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= r_mcand << 1;
                    r_mpy   <= r_mpy >> 1;
                    r_cnt   <= r_cnt + 5'd1;
                    if (w_mul_last) begin
                        r_done  <= 1'b1;
                        r_regw  <= REGW_MULTI;
                        r_dr    <= r_mdr;
                        r_wdata <= w_acc_next[WIDTH-1:0];
                        r_z     <= (w_acc_next[WIDTH-1:0] == '0);
                        r_c     <= |w_acc_next[2*WIDTH-1:WIDTH];
                    end
                end
            endcase
        end
    end

    assign busy       = (r_state == S_MUL);
    assign done       = r_done;
    assign RegW       = r_regw;
    assign DR         = r_dr;
    assign Write_data = r_wdata;
    assign Z          = r_z;
    assign C          = r_c;

endmodule

// File: tb/tb_alu_execute_unit.sv
// tb_alu_execute_unit: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the execute stage.
module tb_alu_execute_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [3:0]  dr_in;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [1:0]  RegW;
    logic [3:0]  DR;
    logic [15:0] Write_data;
    logic        Z;
    logic        C;

    int total = 0;
    int bad   = 0;

    alu_execute_unit #(
        .WIDTH(16),
        .MUL_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .dr_in(dr_in),
        .A(A),
        .B(B),
        .busy(busy),
        .done(done),
        .RegW(RegW),
        .DR(DR),
        .Write_data(Write_data),
        .Z(Z),
        .C(C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Plain-arithmetic reference for the single-cycle ops.
    function automatic void ref_op(input logic [2:0] o, input logic [15:0] a,
                                   input logic [15:0] b,
                                   output logic [15:0] res, output logic c);
        int ai, bi, n, s;
        ai = int'(a);
        bi = int'(b);
        n  = bi % 16;
        res = 16'h0;
        c   = 1'b0;
        case (o)
            3'd0: begin
                s = ai + bi;
                res = 16'(s);
                c = (s > 65535);
            end
            3'd1: begin
                s = ai - bi + 65536;
                res = 16'(s);
                c = (ai < bi);
            end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: begin
                res = 16'(ai * (1 << n));
                c = (n != 0) && (((ai >> (16 - n)) & 1) == 1);
            end
            3'd6: begin
                res = 16'(ai / (1 << n));
                c = (n != 0) && (((ai >> (n - 1)) & 1) == 1);
            end
            default: ;
        endcase
    endfunction

    // Model state: a MUL is just a precomputed product and a countdown.
    logic        m_valid = 1'b0;
    logic        m_busy;
    int          m_left;
    logic [31:0] m_prod;
    logic [3:0]  m_mdr;
    logic        m_done;
    logic [1:0]  m_regw;
    logic [3:0]  m_dr;
    logic [15:0] m_wd;
    logic        m_z;
    logic        m_c;

    always @(posedge clk) begin
        logic [15:0] r;
        logic        cf;
        m_done = 1'b0;
        m_regw = 2'b10;
        if (rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_left  = 0;
            m_dr    = 4'h0;
            m_wd    = 16'h0;
            m_z     = 1'b0;
            m_c     = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_regw = 2'b11;
                m_dr   = m_mdr;
                m_wd   = m_prod[15:0];
                m_z    = (m_prod[15:0] == 16'h0);
                m_c    = (m_prod[31:16] != 16'h0);
            end
        end else if (start) begin
            if (op == 3'd7) begin
                m_busy = 1'b1;
                m_left = 16;
                m_prod = {16'h0, A} * {16'h0, B};
                m_mdr  = dr_in;
            end else begin
                ref_op(op, A, B, r, cf);
                m_done = 1'b1;
                m_regw = 2'b01;
                m_dr   = dr_in;
                m_wd   = r;
                m_z    = (r == 16'h0);
                m_c    = cf;
            end
        end
        #1;
        if (m_valid) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("RegW", 32'(RegW), 32'(m_regw));
            chk("DR", 32'(DR), 32'(m_dr));
            chk("Write_data", 32'(Write_data), 32'(m_wd));
            chk("Z", 32'(Z), 32'(m_z));
            chk("C", 32'(C), 32'(m_c));
        end
    end

    task automatic issue(input logic [2:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] d);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        dr_in = d;
        @(negedge clk);
    endtask

    task automatic wait_done(input string name, input int exp_cycles);
        int i;
        start = 1'b0;
        for (i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk(name, 32'(i), 32'(exp_cycles));
    endtask

    initial begin
        int ndone;
        logic saw_w;
        rst   = 1'b1;
        start = 1'b1;
        op    = 3'd0;
        dr_in = 4'hF;
        A     = 16'hFFFF;
        B     = 16'hFFFF;
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst done", 32'(done), 32'h0);
        chk("rst RegW", 32'(RegW), 32'h2);
        chk("rst DR", 32'(DR), 32'h0);
        chk("rst WD", 32'(Write_data), 32'h0);
        chk("rst ZC", 32'({Z, C}), 32'h0);
        rst = 1'b0;

        issue(3'd0, 16'hFFFF, 16'h0001, 4'd3);
        chk("add done/RegW", 32'({done, RegW}), 32'h5);
        chk("add DR", 32'(DR), 32'd3);
        chk("add WD", 32'(Write_data), 32'h0000);
        chk("add ZC", 32'({Z, C}), 32'h3);
        issue(3'd1, 16'h0005, 16'h0007, 4'd4);
        chk("sub WD", 32'(Write_data), 32'hFFFE);
        chk("sub ZC", 32'({Z, C}), 32'h1);
        issue(3'd5, 16'h8001, 16'h0001, 4'd1);
        chk("shl WD", 32'(Write_data), 32'h0002);
        chk("shl C", 32'(C), 32'h1);
        issue(3'd6, 16'h8001, 16'h0000, 4'd2);
        chk("shr WD", 32'(Write_data), 32'h8001);
        chk("shr C", 32'(C), 32'h0);

        issue(3'd7, 16'h0123, 16'h0045, 4'd9);
        chk("mul busy", 32'({busy, done, RegW}), 32'hA);
        wait_done("mul latency", 16);
        chk("mul RegW", 32'(RegW), 32'h3);
        chk("mul DR", 32'(DR), 32'd9);
        chk("mul WD", 32'(Write_data), 32'h4E6F);
        chk("mul C", 32'(C), 32'h0);
        chk("mul busy end", 32'(busy), 32'h0);

        issue(3'd7, 16'h1234, 16'h0100, 4'd2);
        wait_done("mulov latency", 16);
        chk("mulov WD", 32'(Write_data), 32'h3400);
        chk("mulov ZC", 32'({Z, C}), 32'h1);

        issue(3'd7, 16'h0007, 16'h0009, 4'd5);
        start = 1'b0;
        repeat (4) @(negedge clk);
        issue(3'd0, 16'h1111, 16'h2222, 4'd6);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) ndone++;
            if (done) chk("busy-ign WD", 32'(Write_data), 32'd63);
        end
        chk("busy-ign count", 32'(ndone), 32'd1);

        issue(3'd7, 16'h00FF, 16'h00FF, 4'd7);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        saw_w = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done || RegW != 2'b10) saw_w = 1'b1;
        end
        chk("abort no write", 32'(saw_w), 32'h0);
        issue(3'd0, 16'h0002, 16'h0003, 4'd1);
        chk("post-abort add", 32'({done, DR, Write_data}), 32'h10005 | 32'h1_0000 << 4);
        start = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 1) == 1);
            op    = 3'($urandom_range(0, 7));
            A     = 16'($urandom);
            B     = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15))
                                                : 16'($urandom);
            dr_in = 4'($urandom);
            @(negedge clk);
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
